// File: rtl/inst_fetch_queue_if.sv
// Handshake bus between instruction fetch, the fetch queue and the ID stage.
// The queue takes the slave modport; the fetch/decode side takes master.
interface inst_fetch_queue_if #(
    parameter int PTR_W = 2
) ();
    logic             flush;
    logic             in_valid;
    logic             in_ready;
    logic [31:0]      in_pc;
    logic [31:0]      in_inst;
    logic             out_valid;
    logic             out_ready;
    logic [31:0]      out_pc;
    logic [31:0]      out_inst;
    logic [5:0]       out_op;
    logic [4:0]       out_rs;
    logic [4:0]       out_rt;
    logic [5:0]       out_funct;
    logic             out_adel;
    logic [PTR_W:0]   count;

    modport master (
        output flush, in_valid, in_pc, in_inst, out_ready,
        input  in_ready, out_valid, out_pc, out_inst, out_op, out_rs, out_rt,
               out_funct, out_adel, count
    );

    modport slave (
        input  flush, in_valid, in_pc, in_inst, out_ready,
        output in_ready, out_valid, out_pc, out_inst, out_op, out_rs, out_rt,
               out_funct, out_adel, count
    );
endinterface

// File: rtl/inst_fetch_queue.sv
// Fetch-to-decode FIFO of {pc, inst} pairs with head fields pre-sliced for decode.
// Define IFQ_ADEL_CHECK_EN to flag misaligned PCs on push and turn those words into NOPs.
module inst_fetch_queue #(
    parameter int DEPTH = 4,
    parameter int PTR_W = 2
) (
    input  logic                  clk,
    input  logic                  rst,
    inst_fetch_queue_if.slave     bus
);
    localparam logic [PTR_W:0] FULL_CNT = (PTR_W+1)'(DEPTH);

    logic [31:0]      pc_q   [DEPTH];
    logic [31:0]      inst_q [DEPTH];
    logic [PTR_W-1:0] wp_q, wp_d;
    logic [PTR_W-1:0] rp_q, rp_d;
    logic [PTR_W:0]   count_q, count_d;
    logic             out_valid;
    logic             push;
    logic             pop;
    logic [31:0]      wr_inst;
    logic             head_adel;

    // in_ready looks only at occupancy, so there is no ready path from decode back to fetch.
    assign bus.in_ready = (count_q != FULL_CNT);
    assign out_valid    = (count_q != '0);
    assign push         = bus.in_valid && bus.in_ready && !bus.flush;
    assign pop          = out_valid && bus.out_ready && !bus.flush;

`ifdef IFQ_ADEL_CHECK_EN
    logic adel_q [DEPTH];
    logic wr_adel;

    assign wr_adel   = (bus.in_pc[1:0] != 2'b00);
    assign wr_inst   = wr_adel ? 32'h0 : bus.in_inst;
    assign head_adel = adel_q[rp_q];

    always_ff @(posedge clk) begin
        if (push) adel_q[wp_q] <= wr_adel;
    end
`else
    assign wr_inst   = bus.in_inst;
    assign head_adel = 1'b0;
`endif

    // NOTE: storage has no reset; stale entries are hidden by the !out_valid masking below.
    always_ff @(posedge clk) begin
        if (push) begin
            pc_q[wp_q]   <= bus.in_pc;
            inst_q[wp_q] <= wr_inst;
        end
    end

    always_comb begin
        // NOTE: every next-state value gets its default first so no latch is inferred.
        wp_d    = wp_q;
        rp_d    = rp_q;
        count_d = count_q;
        if (bus.flush) begin
            wp_d    = '0;
            rp_d    = '0;
            count_d = '0;
        end else begin
            if (push) wp_d = wp_q + 1'b1;
            if (pop)  rp_d = rp_q + 1'b1;
            case ({push, pop})
                2'b10:   count_d = count_q + 1'b1;
                2'b01:   count_d = count_q - 1'b1;
                default: count_d = count_q;
            endcase
        end
    end

    // NOTE: state registers use non-blocking assignments so all flops update together.
    always_ff @(posedge clk) begin
        if (rst) begin
            wp_q    <= '0;
            rp_q    <= '0;
            count_q <= '0;
        end else begin
            wp_q    <= wp_d;
            rp_q    <= rp_d;
            count_q <= count_d;
        end
    end

    assign bus.out_valid = out_valid;
    assign bus.out_pc    = out_valid ? pc_q[rp_q]   : 32'h0;
    assign bus.out_inst  = out_valid ? inst_q[rp_q] : 32'h0;
    assign bus.out_adel  = out_valid & head_adel;
    assign bus.out_op    = bus.out_inst[31:26];
    assign bus.out_rs    = bus.out_inst[25:21];
    assign bus.out_rt    = bus.out_inst[20:16];
    assign bus.out_funct = bus.out_inst[5:0];
    assign bus.count     = count_q;
endmodule

// File: tb/tb_inst_fetch_queue.sv
// Self-checking bench for inst_fetch_queue: directed scenarios plus random traffic
// compared against a queue-based reference model.
module tb_inst_fetch_queue;
    localparam int DEPTH = 4;
    localparam int PTR_W = 2;

    typedef struct {
        logic [31:0] pc;
        logic [31:0] inst;
        logic        adel;
    } ent_t;

    logic clk = 1'b0;
    logic rst = 1'b0;
    int   total = 0;
    int   bad   = 0;
    ent_t mq[$];

    inst_fetch_queue_if #(.PTR_W(PTR_W)) bus ();

    inst_fetch_queue #(.DEPTH(DEPTH), .PTR_W(PTR_W)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: time limit reached, got=running required=finished");
        $fatal(1, "watchdog");
    end

    function automatic ent_t mk(input logic [31:0] pc, input logic [31:0] inst);
        ent_t e;
        e.pc = pc;
`ifdef IFQ_ADEL_CHECK_EN
        e.adel = (pc[1:0] != 2'b00);
        e.inst = e.adel ? 32'h0 : inst;
`else
        e.adel = 1'b0;
        e.inst = inst;
`endif
        return e;
    endfunction

    // Apply the queue rules to the model for the inputs currently driven, then advance one edge.
    task automatic tick();
        bit acc;
        bit pop;
        ent_t e;
        acc = bus.in_valid && (mq.size() < DEPTH) && !bus.flush;
        pop = (mq.size() != 0) && bus.out_ready && !bus.flush;
        e   = mk(bus.in_pc, bus.in_inst);
        @(posedge clk);
        if (rst || bus.flush) mq.delete();
        else begin
            if (pop) void'(mq.pop_front());
            if (acc) mq.push_back(e);
        end
        #1;
    endtask

    task automatic idle_inputs();
        bus.flush     = 1'b0;
        bus.in_valid  = 1'b0;
        bus.in_pc     = 32'h0;
        bus.in_inst   = 32'h0;
        bus.out_ready = 1'b0;
    endtask

    task automatic do_reset();
        idle_inputs();
        rst = 1'b1;
        tick();
        rst = 1'b0;
    endtask

    task automatic push_n(input int n, input logic [31:0] pc0, input logic [31:0] inst0);
        bus.out_ready = 1'b0;
        for (int i = 0; i < n; i++) begin
            bus.in_valid = 1'b1;
            bus.in_pc    = pc0 + 32'(4 * i);
            bus.in_inst  = inst0 + 32'(i);
            tick();
        end
        bus.in_valid = 1'b0;
    endtask

    task automatic test_reset();
        do_reset();
        total++; if (bus.count !== 3'd0)     begin bad++; $display("FAIL reset_count got=%0d exp=0", bus.count); end
        total++; if (bus.out_valid !== 1'b0) begin bad++; $display("FAIL reset_out_valid got=%b exp=0", bus.out_valid); end
        total++; if (bus.in_ready !== 1'b1)  begin bad++; $display("FAIL reset_in_ready got=%b exp=1", bus.in_ready); end
        total++; if (bus.out_inst !== 32'h0) begin bad++; $display("FAIL reset_out_inst got=%h exp=0", bus.out_inst); end
        total++; if (bus.out_pc !== 32'h0)   begin bad++; $display("FAIL reset_out_pc got=%h exp=0", bus.out_pc); end
        total++; if (bus.out_adel !== 1'b0)  begin bad++; $display("FAIL reset_out_adel got=%b exp=0", bus.out_adel); end
    endtask

    task automatic test_fill_drain();
        do_reset();
        push_n(4, 32'hBFC0_0000, 32'h2408_0001);
        total++; if (bus.count !== 3'd4)    begin bad++; $display("FAIL fill_count got=%0d exp=4", bus.count); end
        total++; if (bus.in_ready !== 1'b0) begin bad++; $display("FAIL fill_in_ready got=%b exp=0", bus.in_ready); end
        bus.out_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            total++; if (bus.out_pc !== 32'hBFC0_0000 + 32'(4 * i))
                begin bad++; $display("FAIL drain_pc[%0d] got=%h exp=%h", i, bus.out_pc, 32'hBFC0_0000 + 32'(4 * i)); end
            total++; if (bus.out_inst !== 32'h2408_0001 + 32'(i))
                begin bad++; $display("FAIL drain_inst[%0d] got=%h exp=%h", i, bus.out_inst, 32'h2408_0001 + 32'(i)); end
            total++; if (bus.out_op !== 6'h09 || bus.out_rs !== 5'd0 || bus.out_rt !== 5'd8 || bus.out_funct !== 6'(i + 1))
                begin bad++; $display("FAIL drain_fields[%0d] got=%h/%h/%h/%h exp=09/00/08/%h", i, bus.out_op, bus.out_rs, bus.out_rt, bus.out_funct, 6'(i + 1)); end
            tick();
        end
        total++; if (bus.out_valid !== 1'b0 || bus.out_inst !== 32'h0)
            begin bad++; $display("FAIL drain_empty got=%b/%h exp=0/0", bus.out_valid, bus.out_inst); end
        bus.out_ready = 1'b0;
    endtask

    task automatic test_streaming();
        logic [31:0] prev_inst;
        do_reset();
        bus.out_ready = 1'b1;
        bus.in_valid  = 1'b1;
        bus.in_pc     = 32'h0040_0000;
        bus.in_inst   = $urandom;
        prev_inst     = bus.in_inst;
        tick();
        for (int i = 0; i < 20; i++) begin
            total++; if (bus.count !== 3'd1 || bus.out_valid !== 1'b1)
                begin bad++; $display("FAIL stream_occ[%0d] got=%0d/%b exp=1/1", i, bus.count, bus.out_valid); end
            total++; if (bus.out_inst !== prev_inst)
                begin bad++; $display("FAIL stream_inst[%0d] got=%h exp=%h", i, bus.out_inst, prev_inst); end
            bus.in_pc   = bus.in_pc + 32'd4;
            bus.in_inst = $urandom;
            prev_inst   = bus.in_inst;
            tick();
        end
        idle_inputs();
    endtask

    task automatic test_full_backpressure();
        do_reset();
        push_n(4, 32'h1000_0000, 32'h2408_0010);
        bus.in_valid = 1'b1;
        bus.in_pc    = 32'h1000_0100;
        bus.in_inst  = 32'h8C09_0010;
        for (int i = 0; i < 3; i++) begin
            total++; if (bus.in_ready !== 1'b0 || bus.count !== 3'd4 || bus.out_pc !== 32'h1000_0000)
                begin bad++; $display("FAIL full_hold[%0d] got=%b/%0d/%h exp=0/4/10000000", i, bus.in_ready, bus.count, bus.out_pc); end
            tick();
        end
        // Pop frees a slot; the held word is taken on the following edge.
        bus.out_ready = 1'b1;
        tick();
        bus.out_ready = 1'b0;
        total++; if (bus.count !== 3'd3 || bus.in_ready !== 1'b1)
            begin bad++; $display("FAIL full_after_pop got=%0d/%b exp=3/1", bus.count, bus.in_ready); end
        tick();
        bus.in_valid = 1'b0;
        total++; if (bus.count !== 3'd4) begin bad++; $display("FAIL full_refill got=%0d exp=4", bus.count); end
        bus.out_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            total++; if (bus.out_inst !== mq[0].inst || bus.out_pc !== mq[0].pc)
                begin bad++; $display("FAIL full_drain[%0d] got=%h/%h exp=%h/%h", i, bus.out_pc, bus.out_inst, mq[0].pc, mq[0].inst); end
            tick();
        end
        total++; if (mq.size() != 0 || bus.out_valid !== 1'b0)
            begin bad++; $display("FAIL full_final got=%b exp=0", bus.out_valid); end
        idle_inputs();
    endtask

    task automatic test_flush();
        do_reset();
        push_n(3, 32'h2000_0000, 32'h0000_1111);
        bus.flush     = 1'b1;
        bus.in_valid  = 1'b1;
        bus.in_pc     = 32'h2000_0100;
        bus.in_inst   = 32'hDEAD_BEEF;
        bus.out_ready = 1'b1;
        total++; if (bus.in_ready !== 1'b1) begin bad++; $display("FAIL flush_in_ready got=%b exp=1", bus.in_ready); end
        tick();
        idle_inputs();
        total++; if (bus.count !== 3'd0 || bus.out_valid !== 1'b0 || bus.out_inst !== 32'h0)
            begin bad++; $display("FAIL flush_clear got=%0d/%b/%h exp=0/0/0", bus.count, bus.out_valid, bus.out_inst); end
        tick();
        total++; if (bus.out_valid !== 1'b0) begin bad++; $display("FAIL flush_no_ghost got=%b exp=0", bus.out_valid); end
        // Flush on a full queue: in_ready reflects the pre-flush occupancy.
        push_n(4, 32'h2000_0200, 32'h0000_2222);
        bus.flush = 1'b1;
        total++; if (bus.in_ready !== 1'b0) begin bad++; $display("FAIL flush_full_ready got=%b exp=0", bus.in_ready); end
        tick();
        bus.flush = 1'b0;
        total++; if (bus.count !== 3'd0 || bus.in_ready !== 1'b1)
            begin bad++; $display("FAIL flush_full_clear got=%0d/%b exp=0/1", bus.count, bus.in_ready); end
        // Reset wins over flush and clears a partly filled queue.
        push_n(2, 32'h2000_0300, 32'h0000_3333);
        rst = 1'b1; bus.flush = 1'b1; bus.in_valid = 1'b1;
        tick();
        rst = 1'b0;
        idle_inputs();
        total++; if (bus.count !== 3'd0 || bus.out_valid !== 1'b0)
            begin bad++; $display("FAIL rst_over_flush got=%0d/%b exp=0/0", bus.count, bus.out_valid); end
    endtask

    task automatic test_wrap_random();
        int pushed = 0;
        int popped = 0;
        int cyc    = 0;
        logic [31:0] exp_pc, exp_inst;
        logic        exp_valid;
        do_reset();
        while ((pushed < 3 * DEPTH + 1 || mq.size() != 0) && cyc < 1000) begin
            bus.in_valid  = (pushed < 3 * DEPTH + 1) && ($urandom_range(0, 3) != 0);
            bus.in_pc     = 32'h3000_0000 + 32'(4 * pushed);
            bus.in_inst   = $urandom;
            bus.out_ready = ($urandom_range(0, 1) == 1);
            exp_valid = (mq.size() != 0);
            exp_pc    = exp_valid ? mq[0].pc   : 32'h0;
            exp_inst  = exp_valid ? mq[0].inst : 32'h0;
            total++;
            if (bus.out_valid !== exp_valid || bus.out_pc !== exp_pc || bus.out_inst !== exp_inst ||
                bus.count !== (PTR_W+1)'(mq.size()) || bus.in_ready !== (mq.size() < DEPTH)) begin
                bad++;
                $display("FAIL wrap[%0d] got=%b/%h/%h/%0d exp=%b/%h/%h/%0d", cyc,
                         bus.out_valid, bus.out_pc, bus.out_inst, bus.count,
                         exp_valid, exp_pc, exp_inst, mq.size());
            end
            total++; if (bus.count > 3'd4) begin bad++; $display("FAIL wrap_bound[%0d] got=%0d exp<=4", cyc, bus.count); end
            if (bus.in_valid && mq.size() < DEPTH) pushed++;
            if (exp_valid && bus.out_ready) popped++;
            tick();
            cyc++;
        end
        total++; if (popped != 3 * DEPTH + 1)
            begin bad++; $display("FAIL wrap_done got=%0d exp=%0d", popped, 3 * DEPTH + 1); end
        idle_inputs();
    endtask

    task automatic test_adel();
        do_reset();
        bus.in_valid = 1'b1;
        bus.in_pc    = 32'hBFC0_0002;
        bus.in_inst  = 32'h8C09_0000;
        tick();
        idle_inputs();
`ifdef IFQ_ADEL_CHECK_EN
        total++; if (bus.out_adel !== 1'b1 || bus.out_inst !== 32'h0 || bus.out_op !== 6'h0)
            begin bad++; $display("FAIL adel_on got=%b/%h/%h exp=1/00000000/00", bus.out_adel, bus.out_inst, bus.out_op); end
`else
        total++; if (bus.out_adel !== 1'b0 || bus.out_inst !== 32'h8C09_0000 || bus.out_op !== 6'h23)
            begin bad++; $display("FAIL adel_off got=%b/%h/%h exp=0/8c090000/23", bus.out_adel, bus.out_inst, bus.out_op); end
`endif
        total++; if (bus.out_pc !== 32'hBFC0_0002) begin bad++; $display("FAIL adel_pc got=%h exp=bfc00002", bus.out_pc); end
        bus.out_ready = 1'b1;
        bus.in_valid  = 1'b1;
        bus.in_pc     = 32'hBFC0_0004;
        bus.in_inst   = 32'h8C09_0004;
        tick();
        idle_inputs();
        total++; if (bus.out_adel !== 1'b0 || bus.out_inst !== 32'h8C09_0004)
            begin bad++; $display("FAIL adel_aligned got=%b/%h exp=0/8c090004", bus.out_adel, bus.out_inst); end
    endtask

    initial begin
        idle_inputs();
        test_reset();
        test_fill_drain();
        test_streaming();
        test_full_backpressure();
        test_flush();
        test_wrap_random();
        test_adel();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
